// File: rtl/conv_pe_stream_mc.sv
// conv_pe_stream_mc
// Streaming KxK 2D convolution processing element over a square feature map.
// C_IN channels arrive in parallel, one pixel per accepted beat in raster order.
// Results are decimated by STRIDE in both dimensions, with optional ReLU.
// Weights and bias are double-buffered. The shadow bank is copied into the
// active bank only at the frame boundary, so a frame always sees one bank.
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_valid/o_ready/i_data   input pixel stream (channel c at [c*DATA_W +: DATA_W])
//   o_valid/i_ready/o_data   output result stream, o_last marks last result of a frame
//   i_w_we/i_w_addr/i_w_data shadow weight/bias write (addr C_IN*K*K is the bias)
//   i_w_commit, o_w_pending  request/pending flag for shadow->active copy
//   i_relu                   ReLU enable, travels with each accepted pixel
module conv_pe_stream_mc #(
  parameter int KERNEL_SIZE = 3,
  parameter int FM_SIZE     = 8,
  parameter int STRIDE      = 1,
  parameter int C_IN        = 2,
  parameter int DATA_W      = 16,
  parameter int W_W         = 16,
  parameter int ACC_W       = 48,
  localparam int NW         = C_IN * KERNEL_SIZE * KERNEL_SIZE,
  localparam int AW         = $clog2(NW + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [C_IN*DATA_W-1:0]   i_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [ACC_W-1:0]         o_data,
  output logic                     o_last,
  input  logic                     i_w_we,
  input  logic [AW-1:0]            i_w_addr,
  input  logic [W_W-1:0]           i_w_data,
  input  logic                     i_w_commit,
  input  logic                     i_relu,
  output logic                     o_w_pending
);

  localparam int K        = KERNEL_SIZE;
  localparam int KK       = K * K;
  localparam int CW       = $clog2(FM_SIZE);
  localparam int RW       = $clog2(K);
  // Row/col of the final firing pixel of a frame (identical in both axes).
  localparam int LAST_POS = (K - 1) + ((FM_SIZE - K) / STRIDE) * STRIDE;
  localparam logic [CW-1:0] COL_MAX  = CW'(FM_SIZE - 1);
  localparam logic [RW-1:0] RSEL_MAX = RW'(K - 1);

  logic [CW-1:0] row_q, row_d, col_q, col_d;
  logic [RW-1:0] rsel_q, rsel_d;   // line-buffer slot holding the current row
  logic          adv_s, accept_s, fire_s, last_s, copy_s;
  logic          pend_q, pend_d;

  logic signed [DATA_W-1:0] lb_q [C_IN][K][FM_SIZE];
  logic signed [DATA_W-1:0] win_s [NW];
  logic signed [W_W-1:0]    w_sh_q [NW+1];
  logic signed [W_W-1:0]    w_act_q [NW+1];
  logic signed [ACC_W-1:0]  prod_s [NW];

  logic signed [ACC_W-1:0]  s1_prod_q [NW];
  logic signed [ACC_W-1:0]  s1_bias_q;
  logic                     s1_vld_q, s1_last_q, s1_relu_q;
  logic signed [ACC_W-1:0]  sum_s, s2_sum_q;
  logic                     s2_vld_q, s2_last_q, s2_relu_q;
  logic                     o_valid_q, o_last_q;
  logic signed [ACC_W-1:0]  o_data_q;

  // Whole pipeline moves together whenever the output slot is free or draining.
  assign adv_s       = !o_valid_q || i_ready;
  assign accept_s    = i_valid && adv_s;
  assign o_ready     = adv_s;
  assign o_valid     = o_valid_q;
  assign o_data      = o_data_q;
  assign o_last      = o_last_q;
  assign o_w_pending = pend_q;

  // Raster pixel position and line-buffer slot rotation.
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    rsel_d = rsel_q;
    if (accept_s) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        if (row_q == COL_MAX) begin
          row_d  = '0;
          rsel_d = '0;
        end else begin
          row_d  = row_q + 1'b1;
          rsel_d = (rsel_q == RSEL_MAX) ? '0 : rsel_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end else begin
      col_d = col_q;
    end
  end

  // Decide whether the accepted pixel closes a strided window.
  always_comb begin
    int r_off;
    int c_off;
    r_off  = int'(row_q) - (K - 1);
    c_off  = int'(col_q) - (K - 1);
    fire_s = 1'b0;
    last_s = 1'b0;
    if (accept_s && (r_off >= 0) && (c_off >= 0) &&
        ((r_off % STRIDE) == 0) && ((c_off % STRIDE) == 0)) begin
      fire_s = 1'b1;
      last_s = (int'(row_q) == LAST_POS) && (int'(col_q) == LAST_POS);
    end else begin
      fire_s = 1'b0;
    end
  end

  // Gather the window and multiply by the active weights. The bottom-right tap
  // is the incoming pixel itself since it is not yet in the line buffer.
  always_comb begin
    int pr;
    int pc;
    int idx;
    logic [RW-1:0] prow;
    logic [CW-1:0] pcol;
    pr   = 0;
    pc   = 0;
    idx  = 0;
    prow = '0;
    pcol = '0;
    for (int n = 0; n < NW; n++) begin
      win_s[n]  = '0;
      prod_s[n] = '0;
    end
    for (int c = 0; c < C_IN; c++) begin
      for (int ky = 0; ky < K; ky++) begin
        for (int kx = 0; kx < K; kx++) begin
          idx  = c * KK + ky * K + kx;
          // Oldest retained row sits in the slot after the current one.
          pr   = int'(rsel_q) + 1 + ky;
          pr   = (pr >= K) ? (pr - K) : pr;
          pc   = int'(col_q) + kx - (K - 1);
          prow = RW'(pr);
          pcol = CW'(pc);
          if ((ky == K - 1) && (kx == K - 1)) begin
            win_s[idx] = i_data[c*DATA_W +: DATA_W];
          end else if (pc >= 0) begin
            win_s[idx] = lb_q[c][prow][pcol];
          end else begin
            win_s[idx] = '0;
          end
          prod_s[idx] = ACC_W'(win_s[idx]) * ACC_W'(w_act_q[idx]);
        end
      end
    end
  end

  // Adder tree plus bias over the registered products.
  always_comb begin
    sum_s = s1_bias_q;
    for (int n = 0; n < NW; n++) begin
      sum_s = sum_s + s1_prod_q[n];
    end
  end

  // Copy fires whenever pending and the stream sits at pixel (0,0).
  always_comb begin
    copy_s = pend_q && (row_q == '0) && (col_q == '0);
    if (copy_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q || i_w_commit;
    end
  end

  // Line buffer storage; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (accept_s) begin
      for (int c = 0; c < C_IN; c++) begin
        lb_q[c][rsel_q][col_q] <= i_data[c*DATA_W +: DATA_W];
      end
    end
  end

  // Position counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row_q  <= '0;
      col_q  <= '0;
      rsel_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      rsel_q <= rsel_d;
    end
  end

  // Shadow/active weight banks and commit handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int n = 0; n <= NW; n++) begin
        w_sh_q[n]  <= '0;
        w_act_q[n] <= '0;
      end
      pend_q <= 1'b0;
    end else begin
      if (copy_s) begin
        for (int n = 0; n <= NW; n++) begin
          w_act_q[n] <= w_sh_q[n];
        end
      end
      if (i_w_we && (int'(i_w_addr) <= NW)) begin
        w_sh_q[i_w_addr] <= i_w_data;
      end
      pend_q <= pend_d;
    end
  end

  // Three register stages: products+bias, sum, ReLU/output.
  // Bias is captured with the products so a later commit cannot leak in.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int n = 0; n < NW; n++) begin
        s1_prod_q[n] <= '0;
      end
      s1_bias_q <= '0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_relu_q <= 1'b0;
      s2_sum_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_last_q <= 1'b0;
      s2_relu_q <= 1'b0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      o_data_q  <= '0;
    end else if (adv_s) begin
      s1_vld_q  <= fire_s;
      s1_last_q <= last_s;
      s1_relu_q <= i_relu;
      if (fire_s) begin
        for (int n = 0; n < NW; n++) begin
          s1_prod_q[n] <= prod_s[n];
        end
        s1_bias_q <= ACC_W'(w_act_q[NW]);
      end
      s2_vld_q  <= s1_vld_q;
      s2_last_q <= s1_last_q;
      s2_relu_q <= s1_relu_q;
      if (s1_vld_q) begin
        s2_sum_q <= sum_s;
      end
      o_valid_q <= s2_vld_q;
      o_last_q  <= s2_vld_q && s2_last_q;
      if (s2_vld_q) begin
        o_data_q <= (s2_relu_q && s2_sum_q[ACC_W-1]) ? '0 : s2_sum_q;
      end
    end
  end

endmodule

// File: tb/tb_conv_pe_stream_mc.sv
// Directed bench for conv_pe_stream_mc with K=3, FM=5, C_IN=2.
// dut1 uses STRIDE=1, dut2 uses STRIDE=2; both share the input stimulus.
module tb_conv_pe_stream_mc;
  localparam int K   = 3;
  localparam int FM  = 5;
  localparam int CI  = 2;
  localparam int DW  = 16;
  localparam int WW  = 16;
  localparam int OW  = 48;
  localparam int NW  = CI * K * K;
  localparam int AWD = $clog2(NW + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, valid, rdy_in, we, commit, relu;
  logic [CI*DW-1:0]  data;
  logic [AWD-1:0]    waddr;
  logic [WW-1:0]     wdata;
  logic              rdy1, ov1, ol1, pend1;
  logic              rdy2, ov2, ol2, pend2;
  logic [OW-1:0]     od1, od2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pix_sent = 0;
  int acc_cyc [FM*FM];
  int px [CI][FM][FM];
  int wt [NW+1];

  logic [OW-1:0] q1_data[$];
  bit            q1_last[$];
  int            q1_cyc[$];
  logic [OW-1:0] q2_data[$];
  bit            q2_last[$];
  int            q2_cyc[$];
  logic [OW-1:0] exp_d[$];
  bit            exp_l[$];

  conv_pe_stream_mc #(.KERNEL_SIZE(K), .FM_SIZE(FM), .STRIDE(1), .C_IN(CI),
                      .DATA_W(DW), .W_W(WW), .ACC_W(OW)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(rdy1), .i_data(data),
    .o_valid(ov1), .i_ready(rdy_in), .o_data(od1), .o_last(ol1),
    .i_w_we(we), .i_w_addr(waddr), .i_w_data(wdata), .i_w_commit(commit),
    .i_relu(relu), .o_w_pending(pend1));

  conv_pe_stream_mc #(.KERNEL_SIZE(K), .FM_SIZE(FM), .STRIDE(2), .C_IN(CI),
                      .DATA_W(DW), .W_W(WW), .ACC_W(OW)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(rdy2), .i_data(data),
    .o_valid(ov2), .i_ready(rdy_in), .o_data(od2), .o_last(ol2),
    .i_w_we(we), .i_w_addr(waddr), .i_w_data(wdata), .i_w_commit(commit),
    .i_relu(relu), .o_w_pending(pend2));

  always @(posedge clk) cyc <= cyc + 1;

  // Record every completed output transfer, sampled mid-cycle.
  always @(negedge clk) begin
    if (ov1 && rdy_in) begin
      q1_data.push_back(od1); q1_last.push_back(ol1); q1_cyc.push_back(cyc);
    end
    if (ov2 && rdy_in) begin
      q2_data.push_back(od2); q2_last.push_back(ol2); q2_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_q();
    q1_data.delete(); q1_last.delete(); q1_cyc.delete();
    q2_data.delete(); q2_last.delete(); q2_cyc.delete();
    exp_d.delete(); exp_l.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    valid = 1'b0; we = 1'b0; commit = 1'b0; relu = 1'b0; rdy_in = 1'b1;
    waddr = '0; wdata = '0; data = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pix_sent = 0;
  endtask

  task automatic fill_px(input bit rnd);
    for (int c = 0; c < CI; c++)
      for (int r = 0; r < FM; r++)
        for (int x = 0; x < FM; x++)
          px[c][r][x] = rnd ? (int'($urandom_range(0, 200)) - 100) : 1;
  endtask

  task automatic set_w(input bit rnd, input int val, input int bias);
    for (int n = 0; n < NW; n++) wt[n] = rnd ? (int'($urandom_range(0, 100)) - 50) : val;
    wt[NW] = rnd ? (int'($urandom_range(0, 1000)) - 500) : bias;
  endtask

  task automatic write_shadow();
    for (int a = 0; a <= NW; a++) begin
      we = 1'b1; waddr = AWD'(a); wdata = WW'(wt[a]);
      @(posedge clk); #1;
    end
    we = 1'b0;
  endtask

  // Write shadow, commit, and let the idle (0,0) copy happen.
  task automatic load_weights();
    write_shadow();
    commit = 1'b1;
    @(posedge clk); #1 commit = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_px(input int r, input int x, input bit rl);
    bit ok;
    ok = 1'b0;
    valid = 1'b1; relu = rl;
    for (int c = 0; c < CI; c++) data[c*DW +: DW] = DW'(px[c][r][x]);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rdy1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: pixel (%0d,%0d) never accepted", r, x);
    end
    @(posedge clk); #1;
    acc_cyc[r*FM + x] = cyc;
    pix_sent++;
    valid = 1'b0;
  endtask

  task automatic send_range(input int from, input int to, input bit rl);
    for (int i = from; i <= to; i++) send_px(i / FM, i % FM, rl);
  endtask

  function automatic longint ref_win(input int r, input int x, input bit rl);
    longint s;
    s = longint'(wt[NW]);
    for (int c = 0; c < CI; c++)
      for (int ky = 0; ky < K; ky++)
        for (int kx = 0; kx < K; kx++)
          s += longint'(wt[c*K*K + ky*K + kx]) * longint'(px[c][r-K+1+ky][x-K+1+kx]);
    if (rl && s < 0) s = 0;
    return s;
  endfunction

  // Expected stride-1 results in raster order.
  task automatic build_exp(input bit rl);
    for (int r = K - 1; r < FM; r++)
      for (int x = K - 1; x < FM; x++) begin
        exp_d.push_back(OW'(ref_win(r, x, rl)));
        exp_l.push_back((r == FM - 1) && (x == FM - 1));
      end
  endtask

  task automatic test_reset();
    logic [OW-1:0] zero;
    zero = '0;
    do_reset();
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %b want 0", ov1); end
    checks++; if (od1 !== zero) begin errors++; $display("FAIL reset_o_data: got %0h want 0", od1); end
    checks++; if (ol1 !== 1'b0) begin errors++; $display("FAIL reset_o_last: got %b want 0", ol1); end
    checks++; if (pend1 !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", pend1); end
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset_o_ready: got %b want 1", rdy1); end
    // Active bank is zero after reset: a frame of ones yields zeros.
    fill_px(1'b0);
    clear_q();
    send_range(0, FM*FM - 1, 1'b0);
    repeat (6) @(posedge clk); #1;
    checks++; if (q1_data.size() != 9) begin errors++; $display("FAIL reset_zero_count: got %0d want 9", q1_data.size()); end
    for (int i = 0; i < q1_data.size(); i++) begin
      checks++; if (q1_data[i] !== zero) begin errors++; $display("FAIL reset_zero_data[%0d]: got %0d want 0", i, $signed(q1_data[i])); end
    end
  endtask

  task automatic test_stride1();
    logic [OW-1:0] e;
    e = OW'(18);
    do_reset();
    fill_px(1'b0); set_w(1'b0, 1, 0);
    load_weights();
    clear_q();
    send_range(0, FM*FM - 1, 1'b0);
    repeat (6) @(posedge clk); #1;
    checks++; if (q1_data.size() != 9) begin errors++; $display("FAIL s1_count: got %0d want 9", q1_data.size()); end
    for (int i = 0; i < q1_data.size(); i++) begin
      checks++; if (q1_data[i] !== e) begin errors++; $display("FAIL s1_data[%0d]: got %0d want 18", i, $signed(q1_data[i])); end
      checks++; if (q1_last[i] !== (i == 8)) begin errors++; $display("FAIL s1_last[%0d]: got %b want %b", i, q1_last[i], (i == 8)); end
    end
    if (q1_cyc.size() > 0) begin
      checks++;
      if (q1_cyc[0] != acc_cyc[2*FM + 2] + 2) begin
        errors++; $display("FAIL s1_latency: first valid at cycle %0d want %0d", q1_cyc[0], acc_cyc[2*FM + 2] + 2);
      end
    end
  endtask

  task automatic test_stride2();
    int fidx [4];
    logic [OW-1:0] e;
    fidx = '{12, 14, 22, 24};
    e = OW'(18);
    do_reset();
    fill_px(1'b0); set_w(1'b0, 1, 0);
    load_weights();
    clear_q();
    send_range(0, FM*FM - 1, 1'b0);
    repeat (6) @(posedge clk); #1;
    checks++; if (q2_data.size() != 4) begin errors++; $display("FAIL s2_count: got %0d want 4", q2_data.size()); end
    for (int i = 0; i < q2_data.size() && i < 4; i++) begin
      checks++; if (q2_data[i] !== e) begin errors++; $display("FAIL s2_data[%0d]: got %0d want 18", i, $signed(q2_data[i])); end
      checks++; if (q2_last[i] !== (i == 3)) begin errors++; $display("FAIL s2_last[%0d]: got %b want %b", i, q2_last[i], (i == 3)); end
      checks++; if (q2_cyc[i] != acc_cyc[fidx[i]] + 2) begin errors++; $display("FAIL s2_fire_cyc[%0d]: got %0d want %0d", i, q2_cyc[i], acc_cyc[fidx[i]] + 2); end
    end
  endtask

  task automatic test_relu_back_to_back();
    logic [OW-1:0] e;
    do_reset();
    fill_px(1'b0); set_w(1'b0, -1, 5);
    load_weights();
    clear_q();
    send_range(0, FM*FM - 1, 1'b0);
    send_range(0, FM*FM - 1, 1'b1);
    repeat (6) @(posedge clk); #1;
    checks++; if (q1_data.size() != 18) begin errors++; $display("FAIL relu_count: got %0d want 18", q1_data.size()); end
    for (int i = 0; i < q1_data.size(); i++) begin
      e = (i < 9) ? OW'(-13) : OW'(0);
      checks++; if (q1_data[i] !== e) begin errors++; $display("FAIL relu_data[%0d]: got %0d want %0d", i, $signed(q1_data[i]), $signed(e)); end
      checks++; if (q1_last[i] !== (i == 8 || i == 17)) begin errors++; $display("FAIL relu_last[%0d]: got %b want %b", i, q1_last[i], (i == 8 || i == 17)); end
    end
  endtask

  task automatic test_stall();
    bit done, prev_stall;
    int stall_cycles;
    logic [OW-1:0] prev_data;
    done = 1'b0; prev_stall = 1'b0; stall_cycles = 0; prev_data = '0;
    do_reset();
    fill_px(1'b1); set_w(1'b1, 0, 0);
    load_weights();
    clear_q();
    build_exp(1'b0);
    fork
      begin
        send_range(0, FM*FM - 1, 1'b0);
        done = 1'b1;
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          if (pix_sent >= 18) break;
        end
        @(posedge clk); #1 rdy_in = 1'b0;
        repeat (4) @(posedge clk);
        #1 rdy_in = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          checks++;
          if (rdy1 !== !(ov1 && !rdy_in)) begin errors++; $display("FAIL stall_o_ready: got %b want %b", rdy1, !(ov1 && !rdy_in)); end
          if (prev_stall) begin
            checks++;
            if (ov1 !== 1'b1 || od1 !== prev_data) begin
              errors++; $display("FAIL stall_hold: got v=%b d=%0d want v=1 d=%0d", ov1, $signed(od1), $signed(prev_data));
            end
          end
          prev_stall = ov1 && !rdy_in;
          prev_data = od1;
          if (prev_stall) stall_cycles++;
        end
      end
    join
    repeat (8) @(posedge clk); #1;
    checks++; if (stall_cycles == 0) begin errors++; $display("FAIL stall_seen: got 0 stalled cycles want >0"); end
    checks++; if (q1_data.size() != exp_d.size()) begin errors++; $display("FAIL stall_count: got %0d want %0d", q1_data.size(), exp_d.size()); end
    for (int i = 0; i < q1_data.size() && i < exp_d.size(); i++) begin
      checks++; if (q1_data[i] !== exp_d[i]) begin errors++; $display("FAIL stall_data[%0d]: got %0d want %0d", i, $signed(q1_data[i]), $signed(exp_d[i])); end
      checks++; if (q1_last[i] !== exp_l[i]) begin errors++; $display("FAIL stall_last[%0d]: got %b want %b", i, q1_last[i], exp_l[i]); end
    end
  endtask

  task automatic test_commit();
    logic [OW-1:0] e;
    do_reset();
    fill_px(1'b0); set_w(1'b0, 1, 0);
    load_weights();
    clear_q();
    send_range(0, 10, 1'b0);
    set_w(1'b0, 2, 0);
    write_shadow();
    commit = 1'b1;
    @(posedge clk); #1 commit = 1'b0;
    checks++; if (pend1 !== 1'b1) begin errors++; $display("FAIL commit_pending_mid: got %b want 1", pend1); end
    send_range(11, FM*FM - 2, 1'b0);
    checks++; if (pend1 !== 1'b1) begin errors++; $display("FAIL commit_pending_late: got %b want 1", pend1); end
    send_range(FM*FM - 1, FM*FM - 1, 1'b0);
    send_range(0, 0, 1'b0);
    checks++; if (pend1 !== 1'b0) begin errors++; $display("FAIL commit_pending_cleared: got %b want 0", pend1); end
    send_range(1, FM*FM - 1, 1'b0);
    repeat (6) @(posedge clk); #1;
    checks++; if (q1_data.size() != 18) begin errors++; $display("FAIL commit_count: got %0d want 18", q1_data.size()); end
    for (int i = 0; i < q1_data.size(); i++) begin
      e = (i < 9) ? OW'(18) : OW'(36);
      checks++; if (q1_data[i] !== e) begin errors++; $display("FAIL commit_data[%0d]: got %0d want %0d", i, $signed(q1_data[i]), $signed(e)); end
    end
  endtask

  task automatic test_midreset();
    do_reset();
    fill_px(1'b0); set_w(1'b0, 1, 0);
    load_weights();
    send_range(0, 2*FM + 2, 1'b0);
    commit = 1'b1;
    @(posedge clk); #1 commit = 1'b0;
    @(posedge clk); #1;
    checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b want 1", ov1); end
    checks++; if (pend1 !== 1'b1) begin errors++; $display("FAIL midrst_pre_pending: got %b want 1", pend1); end
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL midrst_async_valid: got %b want 0", ov1); end
    checks++; if (pend1 !== 1'b0) begin errors++; $display("FAIL midrst_async_pending: got %b want 0", pend1); end
    @(posedge clk); #1 rst_n = 1'b1;
    fill_px(1'b1); set_w(1'b1, 0, 0);
    load_weights();
    clear_q();
    build_exp(1'b0);
    send_range(0, FM*FM - 1, 1'b0);
    repeat (6) @(posedge clk); #1;
    checks++; if (q1_data.size() != exp_d.size()) begin errors++; $display("FAIL midrst_count: got %0d want %0d", q1_data.size(), exp_d.size()); end
    for (int i = 0; i < q1_data.size() && i < exp_d.size(); i++) begin
      checks++; if (q1_data[i] !== exp_d[i]) begin errors++; $display("FAIL midrst_data[%0d]: got %0d want %0d", i, $signed(q1_data[i]), $signed(exp_d[i])); end
    end
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; rdy_in = 1'b1; we = 1'b0; commit = 1'b0;
    relu = 1'b0; waddr = '0; wdata = '0; data = '0;
    test_reset();
    test_stride1();
    test_stride2();
    test_relu_back_to_back();
    test_stall();
    test_commit();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_pe_stream_mc.md
Name: conv_pe_stream_mc

Overview:
- Parametrised successor to the single-channel DSP-cascade PE.
- Streaming KxK 2D convolution over a square FM_SIZE x FM_SIZE feature map, C_IN input channels presented in parallel per pixel, fixed-stride output decimation.
- New relative to the previous PE: valid/ready handshake with backpressure, double-buffered weights and bias with frame-boundary commit, optional ReLU, end-of-frame flag, back-to-back frames.
- Sits between the feature-map reader and the output writer/pooling stage of the conv layer.

Parameters:
- KERNEL_SIZE, 3, kernel edge K; legal range 2..FM_SIZE.
- FM_SIZE, 8, feature-map edge; padding is not supported (zero).
- STRIDE, 1, output decimation in both dimensions, ≥1.
- C_IN, 2, input channels per pixel.
- DATA_W, 16, signed pixel width per channel.
- W_W, 16, signed weight and bias width.
- ACC_W, 48, signed output width; must be ≥ DATA_W+W_W+clog2(K*K*C_IN)+1, so there is no overflow by construction.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input pixel valid.
- o_ready  out  1  input pixel accepted when i_valid&&o_ready.
- i_data  in  C_IN*DATA_W  pixel; channel c at bits [c*DATA_W +: DATA_W].
- o_valid  out  1  output result valid.
- i_ready  in  1  downstream accepts when o_valid&&i_ready.
- o_data  out  ACC_W  convolution result.
- o_last  out  1  marks the final result of a frame, qualified by o_valid.
- i_w_we  in  1  shadow weight/bias write strobe.
- i_w_addr  in  clog2(C_IN*K*K+1)  address = c*K*K + ky*K + kx; address C_IN*K*K selects the bias.
- i_w_data  in  W_W  weight/bias value.
- i_w_commit  in  1  request copy of shadow bank to active bank.
- i_relu  in  1  ReLU enable; sampled with each accepted pixel and carried down the pipeline.
- o_w_pending  out  1  commit requested but not yet applied.

Behaviour:
- Reset (asynchronous): o_valid=0, o_data=0, o_last=0, o_w_pending=0, pixel counters row=col=0, pipeline valids cleared, active and shadow weights and bias = 0. o_ready=1 after reset. Line-buffer contents are don't-care.
- Advance: adv = !o_valid || i_ready. o_ready = adv (combinational from i_ready). All pipeline stages shift only when adv; bubbles shift too.
- Stall: while o_valid && !i_ready, o_data, o_last and o_valid hold; no input is accepted; no data is lost.
- Pixel order: raster, col fastest. On each accepted beat col++; at col=FM_SIZE-1 col wraps to 0 and row++; at (FM_SIZE-1, FM_SIZE-1) both wrap to 0. The next frame follows with no gap.
- Window fire: the accepted pixel at (row,col) completes a window when all of the following hold:
  - row ≥ K-1 and col ≥ K-1;
  - (row-K+1) % STRIDE == 0;
  - (col-K+1) % STRIDE == 0.
- Window result: the window's top-left is (row-K+1, col-K+1). The result is
  - bias + Σ_c Σ_ky Σ_kx w[c][ky][kx] * x[c][top+ky][left+kx],
  - signed arithmetic, all terms sign-extended to ACC_W.
  - If ReLU is on and the result < 0, output 0.
- Latency: the result appears with o_valid=1 exactly 3 advancing cycles after the firing beat is accepted. Nominal stage split: input register → multiply → adder tree + bias → ReLU/output register.
- Non-firing beats produce no output.
- Outputs per frame: ((FM_SIZE-K)/STRIDE+1)^2. o_last=1 on the last of them only.
- Line buffers: the K-1 most recent full rows plus the current row are retained per channel; no clearing is needed between frames.
- Weights:
  - i_w_we writes the shadow bank only, at any time.
  - i_w_commit sets o_w_pending.
  - In any cycle where pending && row==0 && col==0, active <= shadow and pending clears. This occurs at the frame boundary or immediately if idle at (0,0).
  - Because K≥2, no window of the new frame reads active weights before the copy.
  - Commit coinciding with a copy cycle: pending stays cleared (copy already done).
  - A shadow write in the same cycle as the copy is not included in the copy.
- Mid-frame reset: the asynchronous reset clears everything listed above. The next accepted beat is treated as pixel (0,0).

Test Plan:
- K=3, FM=5, STRIDE=1, C_IN=2; all pixels=1, all weights=1, bias=0, i_ready=1 → 9 outputs each 18, o_last on the 9th only, first o_valid 3 cycles after pixel (2,2) accepted.
- Same setup with STRIDE=2 → 4 outputs, each 18, fired at pixels (2,2),(2,4),(4,2),(4,4).
- Weights=-1, bias=5, pixels=1: i_relu=0 → every output -13; i_relu=1 → every output 0.
- Random pixels/weights with i_ready toggled low for 4 cycles mid-stream → o_data held during the stall, results equal the reference model in order, no drops, o_ready low exactly while o_valid&&!i_ready.
- Frame 1 with weights=1; shadow written to 2 and commit pulsed mid-frame 1 → frame 1 outputs 18, o_w_pending=1 until frame 2 start, frame 2 outputs 36.
- Assert i_rst_n=0 mid-frame → o_valid=0 and o_w_pending=0 asynchronously; a subsequent full frame with re-loaded weights matches the reference model.
